cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It consumes the exception code, branch-delay flag and PC carried down the pipeline registers to the memory stage, plus the external interrupt lines. It produces the single `Req` flush signal that every pipeline register obeys, along with the EPC used by `eret`. It also holds SR, Cause, EPC and PRId for `mfc0`/`mtc0` access.

## Interface
- `HANDLER_PC`, default 32'h0000_4180: handler entry address. Informational only; pipeline registers load it on `Req`.
- `PRID`, default 32'h2023_1114: constant returned when reading register 15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `A_In` in 5: CP0 register number for `mfc0`/`mtc0`.
- `Din` in 32: `mtc0` write data.
- `WE` in 1: `mtc0` write enable, asserted while `mtc0` is in the M stage.
- `PC_In` in 32: PC of the M-stage instruction.
- `ExcCode_In` in 5: exception code of the M-stage instruction; 0 means no exception.
- `isdelay_In` in 1: the M-stage instruction sits in a branch delay slot.
- `HWInt` in 6: external interrupt lines; level-sensitive.
- `EXLClr` in 1: `eret` is in the M stage.
- `Req` out 1: combinational flush/redirect request to all pipeline registers and the PC.
- `EPC_Out` out 32: current EPC register value.
- `Dout` out 32: combinational `mfc0` read data for `A_In`.

## Operation
- **Register map:**
  - SR (12): IM = bits [15:10], EXL = bit [1], IE = bit [0]. All other bits read 0.
  - Cause (13): BD = bit [31], IP = bits [15:10], ExcCode = bits [6:2]. All other bits read 0. Read-only to `mtc0`; writes are ignored.
  - EPC (14): 32-bit, writable.
  - PRId (15): reads `PRID`; writes are ignored.
  - Any other address reads 0; writes to it are ignored.
- **Request logic:**
  - `IntReq` = (|(`HWInt` & IM)) & IE & !EXL.
  - `ExcReq` = (`ExcCode_In` != 0) & !EXL.
  - `Req` = (`IntReq` | `ExcReq`) & !`reset`.
- **On a clock edge with `Req`=1:**
  - EXL <= 1.
  - BD <= `isdelay_In`.
  - Cause.ExcCode <= 0 if `IntReq`, else `ExcCode_In`. Interrupts beat synchronous exceptions.
  - EPC <= `PC_In` - 4 if `isdelay_In`, else `PC_In`. Subtraction is 32-bit modulo; `PC_In` is stored unaligned as-is (AdEL/AdES case).
- **Cause.IP** <= `HWInt` on every edge, regardless of EXL or `Req`.
- **`mtc0`:** when `WE`=1 and `Req`=0, write the addressed register.
  - Write to SR updates IM, EXL and IE only.
  - Write to EPC updates all 32 bits.
- **`eret`:** `EXLClr`=1 and `Req`=0 clears EXL on the edge.
- **Priority within one edge:** `Req` > `EXLClr` > `WE`. When `Req` fires, `mtc0` and `eret` in the same cycle are discarded.
- **`mtc0` to SR.EXL with `EXLClr` in the same cycle:** not possible, since only one M-stage instruction exists; if it occurs, `EXLClr` wins.
- **Reads:** `Dout` reflects register state before the edge; a same-cycle write is not bypassed. `EPC_Out` is the registered EPC with no bypass. The stall unit resolves the `mtc0 EPC` → `eret` hazard.

## Timing
- **Reset (asynchronous):** SR=0, Cause=0, EPC=0. `Req`=0, `EPC_Out`=0. `Dout`=0 for addresses 12/13/14.
- **`Req` latency:** zero-cycle (combinational from M-stage inputs). State updates at the same edge on which pipeline registers flush. EXL=1 from the next cycle, which deasserts `Req`, so `Req` is a single-cycle pulse per event.
- **Masked lines:** a masked or disabled interrupt still sets IP one cycle after `HWInt` rises. It raises `Req` as soon as IM/IE are enabled and EXL=0.
- **`eret`:** EXL=0 the cycle after `EXLClr`. A pending enabled interrupt then raises `Req` in that next cycle.
- **Reset mid-exception:** reset asserted in the same cycle as a `Req` forces `Req`=0 immediately, and no state is captured.

## Test plan
- Reset, then read A=12/13/14/15 -> `Dout` = 0, 0, 0, 32'h2023_1114; `Req`=0.
- `ExcCode_In`=5'd10, `PC_In`=32'h3008, `isdelay_In`=1 -> `Req`=1 that cycle. Next cycle: EPC=32'h3004, Cause=32'h8000_0028, EXL=1, `Req`=0.
- `mtc0` SR=32'h0000_0401, then `HWInt`=6'b000001 with `ExcCode_In`=4 in the same cycle -> `Req`=1; Cause.ExcCode=0; IP=6'b000001.
- With EXL=1, `ExcCode_In`=12 -> `Req`=0 and Cause unchanged. Then `EXLClr`=1 -> EXL=0 next cycle.
- `WE`=1, A=14, `Din`=32'h4000, simultaneous `ExcCode_In`=8 at `PC_In`=32'h3010 -> EPC=32'h3010 (write discarded). `mtc0` to A=13 -> Cause unchanged.
- Assert `reset` asynchronously between edges while EXL=1 and EPC=32'h3010 -> all registers read 0 before the next edge.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt controller for the M stage.
// Holds SR, Cause, EPC and PRId and raises the single pipeline flush request.
module cp0_exception_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2023_1114
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A_In,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] PC_In,
  input  logic [4:0]  ExcCode_In,
  input  logic        isdelay_In,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPC_Out,
  output logic [31:0] Dout
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // The handler address is consumed by the pipeline registers, not here.
  logic unused_handler;
  assign unused_handler = ^HANDLER_PC;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCode_In != 5'd0) & ~exl;
  assign Req     = (int_req | exc_req) & ~reset;

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  assign EPC_Out    = epc;

  always_comb begin
    Dout = 32'd0;
    case (A_In)
      5'd12:   Dout = sr_word;
      5'd13:   Dout = cause_word;
      5'd14:   Dout = epc;
      5'd15:   Dout = PRID;
      default: Dout = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      // Flush beats eret, which beats mtc0.
      if (Req) begin
        exl      <= 1'b1;
        bd       <= isdelay_In;
        exc_code <= int_req ? 5'd0 : ExcCode_In;
        epc      <= isdelay_In ? PC_In - 32'd4 : PC_In;
      end else if (EXLClr) begin
        exl <= 1'b0;
      end else if (WE) begin
        if (A_In == 5'd12) begin
          im  <= Din[15:10];
          exl <= Din[1];
          ie  <= Din[0];
        end else if (A_In == 5'd14) begin
          epc <= Din;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit.
// A word-level register model is compared against the DUT every cycle.
module tb_cp0_exception_unit;

  localparam logic [31:0] PRID = 32'h2023_1114;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  A_In = '0;
  logic [31:0] Din = '0;
  logic        WE = 1'b0;
  logic [31:0] PC_In = '0;
  logic [4:0]  ExcCode_In = '0;
  logic        isdelay_In = 1'b0;
  logic [5:0]  HWInt = '0;
  logic        EXLClr = 1'b0;
  logic        Req;
  logic [31:0] EPC_Out;
  logic [31:0] Dout;

  int passed = 0;
  int total = 0;

  logic [31:0] m_sr = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc = '0;

  cp0_exception_unit #(
    .HANDLER_PC(32'h0000_4180),
    .PRID(PRID)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A_In(A_In),
    .Din(Din),
    .WE(WE),
    .PC_In(PC_In),
    .ExcCode_In(ExcCode_In),
    .isdelay_In(isdelay_In),
    .HWInt(HWInt),
    .EXLClr(EXLClr),
    .Req(Req),
    .EPC_Out(EPC_Out),
    .Dout(Dout)
  );

  always #5 clk = ~clk;

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return (m_int() || (ExcCode_In != 5'd0 && !m_sr[1])) && !reset;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    if (a == 5'd15) return PRID;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sr    <= '0;
      m_cause <= '0;
      m_epc   <= '0;
    end else begin
      m_cause[15:10] <= HWInt;
      if (m_req()) begin
        m_sr[1]       <= 1'b1;
        m_cause[31]   <= isdelay_In;
        m_cause[6:2]  <= m_int() ? 5'd0 : ExcCode_In;
        m_epc         <= isdelay_In ? PC_In - 32'd4 : PC_In;
      end else if (EXLClr) begin
        m_sr[1] <= 1'b0;
      end else if (WE) begin
        if (A_In == 5'd12) m_sr <= Din & 32'h0000_FC03;
        else if (A_In == 5'd14) m_epc <= Din;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    check("model_req", {31'd0, Req}, {31'd0, m_req()});
    check("model_epc", EPC_Out, m_epc);
    check("model_dout", Dout, m_read(A_In));
  end

  task automatic drive(input logic [4:0] a, input logic [31:0] din,
                       input logic we, input logic [31:0] pc,
                       input logic [4:0] exc, input logic dly,
                       input logic [5:0] hw, input logic clr);
    @(posedge clk);
    #1;
    A_In = a;
    Din = din;
    WE = we;
    PC_In = pc;
    ExcCode_In = exc;
    isdelay_In = dly;
    HWInt = hw;
    EXLClr = clr;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    drive(12, 0, 0, 0, 0, 0, 0, 0);
    check("rst_sr", Dout, 32'd0);
    check("rst_req", {31'd0, Req}, 32'd0);
    drive(13, 0, 0, 0, 0, 0, 0, 0);
    check("rst_cause", Dout, 32'd0);
    drive(14, 0, 0, 0, 0, 0, 0, 0);
    check("rst_epc", Dout, 32'd0);
    drive(15, 0, 0, 0, 0, 0, 0, 0);
    check("prid", Dout, 32'h2023_1114);

    drive(13, 0, 0, 32'h3008, 10, 1, 0, 0);
    check("exc_req", {31'd0, Req}, 32'd1);
    check("exc_dout_old", Dout, 32'd0);
    drive(14, 0, 0, 0, 0, 0, 0, 0);
    check("exc_req_drop", {31'd0, Req}, 32'd0);
    check("bd_epc", EPC_Out, 32'h3004);
    drive(13, 0, 0, 0, 0, 0, 0, 0);
    check("bd_cause", Dout, 32'h8000_0028);
    drive(12, 0, 0, 0, 0, 0, 0, 0);
    check("exl_set", Dout, 32'h0000_0002);

    drive(13, 0, 0, 32'h3040, 12, 0, 0, 0);
    check("exl_blocks", {31'd0, Req}, 32'd0);
    drive(13, 0, 0, 0, 0, 0, 0, 0);
    check("cause_kept", Dout, 32'h8000_0028);
    drive(12, 0, 0, 0, 0, 0, 0, 1);
    check("eret_req", {31'd0, Req}, 32'd0);
    drive(12, 0, 0, 0, 0, 0, 0, 0);
    check("eret_clr", Dout, 32'd0);

    drive(12, 32'h0000_0401, 1, 0, 0, 0, 0, 0);
    check("mtc0_req", {31'd0, Req}, 32'd0);
    drive(12, 0, 0, 0, 0, 0, 0, 0);
    check("sr_write", Dout, 32'h0000_0401);
    drive(13, 0, 0, 32'h3020, 4, 0, 6'b000001, 0);
    check("int_req", {31'd0, Req}, 32'd1);
    drive(13, 0, 0, 0, 0, 0, 0, 0);
    check("int_cause", Dout, 32'h0000_0400);
    check("int_epc", EPC_Out, 32'h3020);
    drive(12, 0, 0, 0, 0, 0, 6'b000001, 1);
    check("eret_pend", {31'd0, Req}, 32'd0);
    drive(12, 0, 0, 32'h3030, 0, 0, 6'b000001, 0);
    check("pend_req", {31'd0, Req}, 32'd1);
    check("pend_sr", Dout, 32'h0000_0401);
    drive(12, 0, 0, 0, 0, 0, 0, 0);
    check("pend_exl", Dout, 32'h0000_0403);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("unmapped", Dout, 32'd0);

    drive(14, 32'h4000, 1, 32'h3010, 8, 0, 0, 0);
    check("we_vs_req", {31'd0, Req}, 32'd1);
    drive(13, 0, 0, 0, 0, 0, 0, 0);
    check("we_drop_epc", EPC_Out, 32'h3010);
    check("cause_8", Dout, 32'h0000_0020);
    drive(13, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
    drive(13, 0, 0, 0, 0, 0, 0, 0);
    check("cause_ro", Dout, 32'h0000_0020);
    drive(15, 32'h0, 1, 0, 0, 0, 0, 0);
    drive(15, 0, 0, 0, 0, 0, 0, 0);
    check("prid_ro", Dout, 32'h2023_1114);

    drive(14, 0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_epc", EPC_Out, 32'h3010);
    reset = 1'b1;
    #1;
    check("async_epc", EPC_Out, 32'd0);
    check("async_dout", Dout, 32'd0);
    check("async_req", {31'd0, Req}, 32'd0);
    A_In = 5'd12;
    #1;
    check("async_sr", Dout, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    drive(14, 0, 0, 32'h2, 4, 1, 0, 0);
    check("wrap_req", {31'd0, Req}, 32'd1);
    drive(14, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_epc", Dout, 32'hFFFF_FFFE);
    drive(14, 0, 0, 0, 0, 0, 0, 1);
    drive(14, 32'h1234, 1, 0, 0, 0, 0, 0);
    check("epc_wr_old", Dout, 32'hFFFF_FFFE);
    drive(14, 0, 0, 0, 0, 0, 0, 0);
    check("epc_wr", EPC_Out, 32'h1234);

    @(posedge clk);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
